tx_queue_ctrl: RTL and testbench

- Sequences the serial transmitter. Buffers bytes written by the register interface in a FIFO.
- Presents the transmitter with a non-empty indication and hands over one word per data_request pulse.
- Latches the frame-format configuration per frame, so that size, stop2 and parity never change mid-frame.
- Sits between the AXI register block and the transmitter. Exports level and status bits for the status register and interrupt logic.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/tx_fifo_ram.sv | 37 +++
 rtl/tx_queue_ctrl.sv | 154 +++++++++++++++
 tb/tb_tx_queue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Types and constants shared by the serial transmitter, its
//               transmit queue controller and the register block.
//               parity_t     - 2-bit parity mode encoding
//               SERIAL_WIDTH - transmitter data word width
//               TX_FIFO_DEPTH- default transmit queue depth
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_t;

  localparam int SERIAL_WIDTH  = 9;
  localparam int TX_FIFO_DEPTH = 16;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/tx_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_ram
// Description : DEPTH x WIDTH storage for the transmit queue. One synchronous
//               write port, one asynchronous read port. No control logic.
// Ports       : clk      - system clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - read data (combinational from i_raddr)
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : tx_fifo_ram
`default_nettype wire

// File: rtl/tx_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tx_queue_ctrl
// Description : Transmit queue sequencer between the register block and the
//               serial transmitter. Buffers pushed words in a FIFO, hands one
//               word to the transmitter per data_request pulse and latches the
//               frame format at that moment so it is stable for the frame.
// Ports       : clk, reset (sync, active-low)
//               wr_en/wr_data      - push from register block
//               flush, clr_status  - queue discard / sticky status clear
//               cfg_*              - live configuration
//               data_request       - transmitter frame start (pop)
//               tx_*               - transmitter word, frame config, enable
//               full/level/tx_low  - occupancy
//               overflow/underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module tx_queue_ctrl
  import serial_pkg::*;
#(
  parameter int DEPTH  = TX_FIFO_DEPTH,
  parameter int WIDTH  = SERIAL_WIDTH,
  parameter int LOW_WM = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   flush,
  input  logic                   clr_status,
  input  logic                   cfg_enable,
  input  logic                   cfg_size,
  input  logic                   cfg_stop2,
  input  logic [1:0]             cfg_parity,
  input  logic                   data_request,
  output logic                   tx_empty,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_size,
  output logic                   tx_stop2,
  output logic [1:0]             tx_parity,
  output logic                   tx_enable,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_low,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_size;
  logic             r_tx_stop2;
  parity_t          r_tx_parity;
  logic             r_tx_enable;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [WIDTH-1:0] w_head;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0) | ~r_tx_enable;
  assign w_pop   = data_request & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted then. Flush discards any concurrent push.
  assign w_push  = wr_en & (~w_full | w_pop) & ~flush;

  assign w_ovf_set = wr_en & w_full & ~w_pop & ~flush;
  assign w_unf_set = data_request & w_empty;

  tx_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  // Pointers and level; flush overrides any concurrent push or pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Word and frame format are captured together on a pop and held until the
  // next one; flush leaves them alone so an in-flight frame completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_data   <= '0;
      r_tx_size   <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx_parity <= PAR_NONE;
    end else if (w_pop) begin
      r_tx_data   <= w_head;
      r_tx_size   <= cfg_size;
      r_tx_stop2  <= cfg_stop2;
      r_tx_parity <= parity_t'(cfg_parity);
    end
  end

  // Sticky status: a set event in the same cycle as clr_status wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_enable <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tx_enable <= cfg_enable;
      if (w_ovf_set)       r_overflow <= 1'b1;
      else if (clr_status) r_overflow <= 1'b0;
      if (w_unf_set)       r_underflow <= 1'b1;
      else if (clr_status) r_underflow <= 1'b0;
    end
  end

  assign tx_empty  = w_empty;
  assign tx_data   = r_tx_data;
  assign tx_size   = r_tx_size;
  assign tx_stop2  = r_tx_stop2;
  assign tx_parity = r_tx_parity;
  assign tx_enable = r_tx_enable;
  assign full      = w_full;
  assign level     = r_level;
  assign tx_low    = (r_level <= LW'(LOW_WM));
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule : tx_queue_ctrl
`default_nettype wire

// File: tb/tb_tx_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_queue_ctrl
// Description : Directed self-checking bench for tx_queue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_queue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [8:0] wr_data = '0;
  logic       flush = 1'b0;
  logic       clr_status = 1'b0;
  logic       cfg_enable = 1'b0;
  logic       cfg_size = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic [1:0] cfg_parity = 2'd0;
  logic       data_request = 1'b0;
  logic       tx_empty;
  logic [8:0] tx_data;
  logic       tx_size;
  logic       tx_stop2;
  logic [1:0] tx_parity;
  logic       tx_enable;
  logic       full;
  logic [4:0] level;
  logic       tx_low;
  logic       overflow;
  logic       underflow;

  int n_vec = 0;
  int n_err = 0;

  tx_queue_ctrl #(.DEPTH(16), .WIDTH(9), .LOW_WM(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_status   (clr_status),
    .cfg_enable   (cfg_enable),
    .cfg_size     (cfg_size),
    .cfg_stop2    (cfg_stop2),
    .cfg_parity   (cfg_parity),
    .data_request (data_request),
    .tx_empty     (tx_empty),
    .tx_data      (tx_data),
    .tx_size      (tx_size),
    .tx_stop2     (tx_stop2),
    .tx_parity    (tx_parity),
    .tx_enable    (tx_enable),
    .full         (full),
    .level        (level),
    .tx_low       (tx_low),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] w);
    wr_en = 1'b1; wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    data_request = 1'b1;
    step();
    data_request = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    n_vec++;
    if ({tx_empty, full, tx_low, overflow, underflow, tx_enable} !== 6'b101000) begin
      n_err++;
      $display("FAIL reset_flags: got e/f/l/o/u/en=%b required 101000",
               {tx_empty, full, tx_low, overflow, underflow, tx_enable});
    end
    n_vec++;
    if ({level, tx_data, tx_size, tx_stop2, tx_parity} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_data: level=%0d data=%h size=%b stop2=%b par=%0d required all 0",
               level, tx_data, tx_size, tx_stop2, tx_parity);
    end
  endtask

  task automatic test_push_sequence();
    cfg_enable = 1'b1;
    step();
    n_vec++;
    if (tx_enable !== 1'b1) begin
      n_err++; $display("FAIL enable_follow: got %b required 1", tx_enable);
    end
    push(9'h041); push(9'h042); push(9'h043);
    n_vec++;
    if (level !== 5'd3 || tx_empty !== 1'b0) begin
      n_err++; $display("FAIL seq_level: level=%0d empty=%b required 3/0", level, tx_empty);
    end
    for (int i = 0; i < 3; i++) begin
      pop();
      n_vec++;
      if (tx_data !== 9'h041 + 9'(i)) begin
        n_err++; $display("FAIL seq_data[%0d]: got %h required %h", i, tx_data, 9'h041 + 9'(i));
      end
    end
    n_vec++;
    if (level !== 5'd0 || tx_empty !== 1'b1 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL seq_drained: level=%0d empty=%b unf=%b required 0/1/0",
               level, tx_empty, underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      push(9'(i));
      if (i == 3 || i == 4) begin
        n_vec++;
        if (tx_low !== (i == 3)) begin
          n_err++; $display("FAIL low_wm at level %0d: got %b required %b", i + 1, tx_low, i == 3);
        end
      end
    end
    n_vec++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1 || tx_low !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_state: full=%b level=%0d ovf=%b low=%b required 1/16/1/0",
               full, level, overflow, tx_low);
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      n_vec++;
      if (tx_data !== 9'(i)) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got %h required %h", i, tx_data, 9'(i));
      end
    end
    n_vec++;
    if (tx_empty !== 1'b1 || level !== 5'd0) begin
      n_err++; $display("FAIL ovf_empty: empty=%b level=%0d required 1/0", tx_empty, level);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_config_latch();
    cfg_parity = 2'd1;
    push(9'h055);
    pop();
    cfg_parity = 2'd2;
    step();
    n_vec++;
    if (tx_parity !== 2'd1 || tx_data !== 9'h055 || tx_size !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_hold: par=%0d data=%h size=%b required 1/055/0", tx_parity, tx_data, tx_size);
    end
    cfg_size = 1'b1; cfg_stop2 = 1'b1;
    push(9'h0AA);
    pop();
    cfg_size = 1'b0; cfg_stop2 = 1'b0; cfg_parity = 2'd0;
    n_vec++;
    if (tx_parity !== 2'd2 || tx_size !== 1'b1 || tx_stop2 !== 1'b1 || tx_data !== 9'h0AA) begin
      n_err++;
      $display("FAIL cfg_next: par=%0d size=%b stop2=%b data=%h required 2/1/1/0AA",
               tx_parity, tx_size, tx_stop2, tx_data);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(9'h100 + 9'(i));
    wr_en = 1'b1; wr_data = 9'h1AA; data_request = 1'b1;
    step();
    wr_en = 1'b0; data_request = 1'b0;
    n_vec++;
    if (level !== 5'd16 || overflow !== 1'b0 || tx_data !== 9'h100) begin
      n_err++;
      $display("FAIL full_pp: level=%0d ovf=%b data=%h required 16/0/100", level, overflow, tx_data);
    end
    for (int i = 1; i <= 16; i++) begin
      pop();
      n_vec++;
      if (tx_data !== ((i == 16) ? 9'h1AA : 9'h100 + 9'(i))) begin
        n_err++;
        $display("FAIL full_pp_drain[%0d]: got %h required %h", i, tx_data,
                 (i == 16) ? 9'h1AA : 9'h100 + 9'(i));
      end
    end
  endtask

  task automatic test_flush_in_flight();
    for (int i = 0; i < 5; i++) push(9'h0A0 + 9'(i));
    pop();
    n_vec++;
    if (tx_data !== 9'h0A0 || level !== 5'd4) begin
      n_err++; $display("FAIL flush_pre: data=%h level=%0d required 0A0/4", tx_data, level);
    end
    flush = 1'b1; wr_en = 1'b1; wr_data = 9'h1FF;
    step();
    flush = 1'b0; wr_en = 1'b0;
    n_vec++;
    if (level !== 5'd0 || tx_data !== 9'h0A0 || overflow !== 1'b0 || tx_empty !== 1'b1) begin
      n_err++;
      $display("FAIL flush: level=%0d data=%h ovf=%b empty=%b required 0/0A0/0/1",
               level, tx_data, overflow, tx_empty);
    end
  endtask

  task automatic test_enable_gating();
    push(9'h011); push(9'h012);
    cfg_enable = 1'b0;
    step();
    n_vec++;
    if (tx_empty !== 1'b1) begin
      n_err++; $display("FAIL gate_empty: got %b required 1", tx_empty);
    end
    pop();
    n_vec++;
    if (underflow !== 1'b1 || level !== 5'd2 || tx_data !== 9'h0A0) begin
      n_err++;
      $display("FAIL gate_unf: unf=%b level=%0d data=%h required 1/2/0A0", underflow, level, tx_data);
    end
    cfg_enable = 1'b1;
    n_vec++;
    if (tx_empty !== 1'b1) begin
      n_err++; $display("FAIL gate_same_cycle: got %b required 1", tx_empty);
    end
    step();
    n_vec++;
    if (tx_empty !== 1'b0) begin
      n_err++; $display("FAIL gate_reenable: got %b required 0", tx_empty);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    n_vec++;
    if (underflow !== 1'b0) begin
      n_err++; $display("FAIL unf_clear: got %b required 0", underflow);
    end
    do_flush();
  endtask

  task automatic test_reset_mid();
    cfg_parity = 2'd3; cfg_size = 1'b1; cfg_stop2 = 1'b1;
    for (int i = 0; i < 17; i++) push(9'h150 + 9'(i));
    for (int i = 0; i < 9; i++) pop();
    n_vec++;
    if (level !== 5'd7 || overflow !== 1'b1 || tx_parity !== 2'd3) begin
      n_err++;
      $display("FAIL pre_reset: level=%0d ovf=%b par=%0d required 7/1/3", level, overflow, tx_parity);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_vec++;
    if ({tx_empty, full, tx_low, overflow, underflow, tx_enable} !== 6'b101000) begin
      n_err++;
      $display("FAIL mid_reset_flags: got e/f/l/o/u/en=%b required 101000",
               {tx_empty, full, tx_low, overflow, underflow, tx_enable});
    end
    n_vec++;
    if ({level, tx_data, tx_size, tx_stop2, tx_parity} !== 18'd0) begin
      n_err++;
      $display("FAIL mid_reset_data: level=%0d data=%h size=%b stop2=%b par=%0d required all 0",
               level, tx_data, tx_size, tx_stop2, tx_parity);
    end
  endtask

  initial begin
    test_reset();
    test_push_sequence();
    test_overflow();
    test_config_latch();
    test_full_push_pop();
    test_flush_in_flight();
    test_enable_gating();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tx_queue_ctrl
`default_nettype wire
